// File: rtl/note_tone_gen.sv
// ---------------------------------------------------------------------------
// note_tone_gen
//
// Turns an {octave, note} pair from the upstream note divider into a square
// wave on the speaker pin. Each half-period lasts D * (O + 1) clocks, where
// D is the note's base divider and O = 255 >> octave. Two cascaded counters
// produce this: note_cnt counts D clocks, and oct_cnt counts O + 1 passes of
// note_cnt. The speaker toggles when both counters reach zero.
//
// Parameters:
//   NOTE_W  width of the note divider counter (reload D - 1, max 511)
//   OCT_W   width of the octave prescale counter (reload 255 >> octave)
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   note_load  one-cycle strobe, capture octave/note on this edge
//   note_off   one-cycle strobe, silence the tone (wins over note_load)
//   octave     octave 0-7, 0 = lowest pitch (upstream produces 0-5)
//   note       note within octave, valid 0-11; 12-15 silence the block
//   speaker    registered square-wave drive
//   tone_on    high while a valid note is sounding
//
// Build option:
//   TONE_RESTART_EN  When defined, a valid load restarts the phase: the
//                    counters reload with the new D/O and speaker clears.
//                    When undefined, a load changes only the pitch
//                    registers. The counters and speaker keep running, and
//                    the new pitch applies at each counter's next reload.
//                    This gives glitch-free legato between notes.
// ---------------------------------------------------------------------------
module note_tone_gen #(
   parameter int unsigned NOTE_W = 9,
   parameter int unsigned OCT_W  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       note_load,
   input  logic       note_off,
   input  logic [2:0] octave,
   input  logic [3:0] note,
   output logic       speaker,
   output logic       tone_on
);

   // ------------------------------------------------------------------------
   // Lookup helpers
   // ------------------------------------------------------------------------

   // Base divider table, already reduced by one to give the counter reload.
   // Invalid notes (12-15) never sound. They map to the lowest pitch so that
   // the preload value is always defined.
   function automatic logic [NOTE_W-1:0] note_div_m1(input logic [3:0] n);
      logic [NOTE_W-1:0] r;
      unique case (n)
         4'd0:    r = NOTE_W'(511);
         4'd1:    r = NOTE_W'(482);
         4'd2:    r = NOTE_W'(455);
         4'd3:    r = NOTE_W'(430);
         4'd4:    r = NOTE_W'(405);
         4'd5:    r = NOTE_W'(383);
         4'd6:    r = NOTE_W'(361);
         4'd7:    r = NOTE_W'(341);
         4'd8:    r = NOTE_W'(322);
         4'd9:    r = NOTE_W'(303);
         4'd10:   r = NOTE_W'(286);
         4'd11:   r = NOTE_W'(270);
         default: r = NOTE_W'(511);
      endcase
      return r;
   endfunction

   // Octave prescale reload: 255 >> octave, zero-filled to OCT_W.
   function automatic logic [OCT_W-1:0] oct_reload(input logic [2:0] o);
      logic [7:0] full;
      full = 8'hFF >> o;
      return OCT_W'(full);
   endfunction

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------

   logic [2:0]        oct_reg;
   logic [3:0]        note_reg;
   logic [NOTE_W-1:0] note_cnt;
   logic [OCT_W-1:0]  oct_cnt;

   logic [2:0]        oct_reg_nxt;
   logic [3:0]        note_reg_nxt;
   logic [NOTE_W-1:0] note_cnt_nxt;
   logic [OCT_W-1:0]  oct_cnt_nxt;
   logic              speaker_nxt;
   logic              tone_on_nxt;

   // ------------------------------------------------------------------------
   // Decoded strobes and reload values
   // ------------------------------------------------------------------------

   logic              load_acc;     // load accepted (note_off not present)
   logic              note_valid;   // incoming note is in range 0-11
   logic [2:0]        oct_sel;      // pitch selected for a preload this edge
   logic [3:0]        note_sel;
   logic [NOTE_W-1:0] d_cur_m1;     // reload from the stored pitch
   logic [OCT_W-1:0]  o_cur;
   logic [NOTE_W-1:0] d_sel_m1;     // reload from the selected pitch
   logic [OCT_W-1:0]  o_sel;

   always_comb begin
      load_acc   = note_load & ~note_off;
      note_valid = (note <= 4'd11);
      // On an accepted load, a preload must already use the incoming pitch.
      // That way the first toggle after a load from silence lands exactly
      // D * (O + 1) edges later.
      oct_sel    = load_acc ? octave : oct_reg;
      note_sel   = load_acc ? note   : note_reg;
      d_cur_m1   = note_div_m1(note_reg);
      o_cur      = oct_reload(oct_reg);
      d_sel_m1   = note_div_m1(note_sel);
      o_sel      = oct_reload(oct_sel);
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------

   always_comb begin
      oct_reg_nxt  = oct_reg;
      note_reg_nxt = note_reg;
      note_cnt_nxt = note_cnt;
      oct_cnt_nxt  = oct_cnt;
      speaker_nxt  = speaker;
      tone_on_nxt  = tone_on;

      if (note_off) begin
         // Silence the block. The pitch registers are untouched, and the
         // counters preload from them as they would in any silent cycle.
         tone_on_nxt  = 1'b0;
         speaker_nxt  = 1'b0;
         note_cnt_nxt = d_cur_m1;
         oct_cnt_nxt  = o_cur;
      end else begin
         if (note_load) begin
            oct_reg_nxt  = octave;
            note_reg_nxt = note;
            tone_on_nxt  = note_valid;
         end

         if (!tone_on || (note_load && !note_valid)) begin
            // Silent, or going silent: keep the counters preloaded so that
            // the next valid load starts with a full half-period.
            speaker_nxt  = 1'b0;
            note_cnt_nxt = d_sel_m1;
            oct_cnt_nxt  = o_sel;
         end else begin
            // Sounding: cascaded count-down, reload only at zero.
            if (note_cnt != '0) begin
               note_cnt_nxt = note_cnt - 1'b1;
            end else if (oct_cnt != '0) begin
               note_cnt_nxt = d_cur_m1;
               oct_cnt_nxt  = oct_cnt - 1'b1;
            end else begin
               note_cnt_nxt = d_cur_m1;
               oct_cnt_nxt  = o_cur;
               speaker_nxt  = ~speaker;
            end
`ifdef TONE_RESTART_EN
            // A valid load while sounding restarts with a clean phase.
            if (note_load) begin
               note_cnt_nxt = d_sel_m1;
               oct_cnt_nxt  = o_sel;
               speaker_nxt  = 1'b0;
            end
`endif
         end
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         oct_reg  <= '0;
         note_reg <= '0;
         note_cnt <= '0;
         oct_cnt  <= '0;
         speaker  <= 1'b0;
         tone_on  <= 1'b0;
      end else begin
         oct_reg  <= oct_reg_nxt;
         note_reg <= note_reg_nxt;
         note_cnt <= note_cnt_nxt;
         oct_cnt  <= oct_cnt_nxt;
         speaker  <= speaker_nxt;
         tone_on  <= tone_on_nxt;
      end
   end

endmodule

// File: tb/tb_note_tone_gen.sv
// ---------------------------------------------------------------------------
// tb_note_tone_gen
//
// Directed bench for note_tone_gen. A table of {octave, note} records holds
// the expected tone_on level, the half-period in clocks and the number of
// toggles to time. Hand-written sequences cover note_off, a simultaneous
// load and off, re-loading while a note sounds, and an asynchronous reset
// in the middle of a tone.
// ---------------------------------------------------------------------------
module tb_note_tone_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       note_load;
   logic       note_off;
   logic [2:0] octave;
   logic [3:0] note;
   logic       speaker;
   logic       tone_on;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   note_tone_gen dut (
      .clk       (clk),
      .rst       (rst),
      .note_load (note_load),
      .note_off  (note_off),
      .octave    (octave),
      .note      (note),
      .speaker   (speaker),
      .tone_on   (tone_on)
   );

   typedef struct {
      logic [2:0] oct;
      logic [3:0] nt;
      logic       exp_on;
      int         half;      // expected half-period in clocks
      int         toggles;   // toggles to time (0 = check silence)
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic do_load(input logic [2:0] o, input logic [3:0] n,
                          input logic with_off);
      @(negedge clk);
      octave    = o;
      note      = n;
      note_load = 1'b1;
      note_off  = with_off;
      @(posedge clk);
      #1;
      note_load = 1'b0;
      note_off  = 1'b0;
   endtask

   task automatic do_off();
      @(negedge clk);
      note_off = 1'b1;
      @(posedge clk);
      #1;
      note_off = 1'b0;
   endtask

   // Count edges until speaker changes, bounded a little past the expected
   // value. An expired bound reports a count that cannot match.
   task automatic wait_toggle(input string name, input int exp);
      logic start;
      int   n;
      bit   seen;
      start = speaker;
      n     = 0;
      seen  = 1'b0;
      while (n < exp + 16 && !seen) begin
         @(posedge clk);
         #1;
         n++;
         if (speaker !== start) seen = 1'b1;
      end
      check(name, n, exp);
   endtask

   // Speaker must stay low for the given number of clocks.
   task automatic quiet(input string name, input int cycles);
      int highs;
      highs = 0;
      repeat (cycles) begin
         @(posedge clk);
         #1;
         if (speaker !== 1'b0) highs++;
      end
      check(name, highs, 0);
   endtask

   initial begin
      vecs[0] = '{oct: 3'd5, nt: 4'd0,  exp_on: 1'b1, half: 4096, toggles: 3};
      vecs[1] = '{oct: 3'd5, nt: 4'd11, exp_on: 1'b1, half: 2168, toggles: 4};
      vecs[2] = '{oct: 3'd5, nt: 4'd6,  exp_on: 1'b1, half: 2896, toggles: 2};
      vecs[3] = '{oct: 3'd6, nt: 4'd5,  exp_on: 1'b1, half: 1536, toggles: 3};
      vecs[4] = '{oct: 3'd7, nt: 4'd9,  exp_on: 1'b1, half: 608,  toggles: 4};
      vecs[5] = '{oct: 3'd3, nt: 4'd12, exp_on: 1'b0, half: 0,    toggles: 0};

      rst       = 1'b1;
      note_load = 1'b0;
      note_off  = 1'b0;
      octave    = '0;
      note      = '0;
      #12;
      check("reset speaker", speaker, 0);
      check("reset tone_on", tone_on, 0);
      @(negedge clk);
      rst = 1'b0;
      quiet("silent after reset", 200);
      check("tone_on after reset", tone_on, 0);

      // Table-driven pitch checks, each starting from silence.
      for (int i = 0; i < 6; i++) begin
         do_off();
         check($sformatf("v%0d off speaker", i), speaker, 0);
         check($sformatf("v%0d off tone_on", i), tone_on, 0);
         do_load(vecs[i].oct, vecs[i].nt, 1'b0);
         check($sformatf("v%0d tone_on", i), tone_on, vecs[i].exp_on);
         if (vecs[i].exp_on) begin
            for (int t = 0; t < vecs[i].toggles; t++)
               wait_toggle($sformatf("v%0d toggle %0d", i, t), vecs[i].half);
         end else begin
            quiet($sformatf("v%0d invalid silent", i), 3000);
            check($sformatf("v%0d invalid tone_on", i), tone_on, 0);
         end
      end

      // Octave 0 is far too slow to time fully; check that it is on and has
      // not toggled early, then silence it mid-count.
      do_off();
      do_load(3'd0, 4'd0, 1'b0);
      check("oct0 tone_on", tone_on, 1);
      quiet("oct0 no early toggle", 2000);
      do_off();
      check("oct0 off speaker", speaker, 0);
      check("oct0 off tone_on", tone_on, 0);

      // note_off while the speaker is high.
      do_load(3'd7, 4'd9, 1'b0);
      wait_toggle("off-test first toggle", 608);
      check("off-test speaker high", speaker, 1);
      do_off();
      check("off-test speaker", speaker, 0);
      check("off-test tone_on", tone_on, 0);
      quiet("off-test stays silent", 1500);

      // Simultaneous load and off: off wins.
      do_load(3'd7, 4'd9, 1'b0);
      wait_toggle("both-test first toggle", 608);
      do_load(3'd5, 4'd0, 1'b1);
      check("both-test tone_on", tone_on, 0);
      check("both-test speaker", speaker, 0);
      quiet("both-test silent", 500);

      // Re-load octave 4 note 3 while octave 5 note 0 sounds, 904 edges
      // after its first toggle. Counters are then at note_cnt=119, oct_cnt=6.
      do_off();
      do_load(3'd5, 4'd0, 1'b0);
      wait_toggle("reload first toggle", 4096);
      repeat (903) @(posedge clk);
      do_load(3'd4, 4'd3, 1'b0);
      check("reload tone_on", tone_on, 1);
`ifdef TONE_RESTART_EN
      check("reload speaker cleared", speaker, 0);
      wait_toggle("reload restart toggle", 6896);
`else
      check("reload speaker held", speaker, 1);
      // 119 + 1 + 6 * 431 edges: the rest of the old count at the new D.
      wait_toggle("reload legato toggle", 2706);
`endif
      wait_toggle("reload steady toggle", 6896);

      // Asynchronous reset, not aligned to the clock, while speaker is high.
      do_off();
      do_load(3'd7, 4'd9, 1'b0);
      wait_toggle("rst-test first toggle", 608);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("async rst speaker", speaker, 0);
      check("async rst tone_on", tone_on, 0);
      @(negedge clk);
      rst = 1'b0;
      quiet("silent after async rst", 1500);
      check("tone_on after async rst", tone_on, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
